// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Bridges the cache's line-granular downward port (one LINE_W-bit line per
//   request) to a BEAT_W-bit burst memory. A line fill becomes one read
//   request followed by BEATS returning beats; a line writeback becomes BEATS
//   write beats. Completion is a single-cycle dfp_resp back to the cache.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   dfp_addr       : byte address from the cache (line offset bits ignored)
//   dfp_read       : line fill request, held until dfp_resp
//   dfp_write      : line writeback request, held until dfp_resp (wins over read)
//   dfp_wdata      : line to write back
//   dfp_rdata      : assembled fill line (fill buffer register)
//   dfp_resp       : one-cycle completion pulse
//   bmem_addr      : line-aligned burst address
//   bmem_read      : read burst request
//   bmem_write     : write beat valid
//   bmem_wdata     : write beat
//   bmem_ready     : memory accepts the request / beat this cycle
//   bmem_raddr     : address tag of the returning read beat
//   bmem_rdata     : read beat data
//   bmem_rvalid    : read beat valid
//
// All bmem_* and dfp_resp/dfp_rdata outputs come straight from flops, so there
// is no combinational path from dfp_* or bmem_* inputs to any output.

module cacheline_adapter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,

  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEATS  = LINE_W / BEAT_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [LINE_W-1:0]   line_q,  line_d;   // latched writeback line
  logic [LINE_W-1:0]   buf_q,   buf_d;    // fill buffer, drives dfp_rdata
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic                bmem_read_d;
  logic                bmem_write_d;
  logic [BEAT_W-1:0]   bmem_wdata_d;
  logic                dfp_resp_d;

  logic [ADDR_W-1:0]   aligned_addr;
  logic                rbeat_ok;

  // Line offset bits of the request address carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dfp_addr[OFF_W-1:0];

  assign aligned_addr = {dfp_addr[ADDR_W-1:OFF_W], OFF_W'(0)};

  // A read beat counts only in RD_DATA and only if it is tagged with our line.
  assign rbeat_ok = (state_q == RD_DATA) && bmem_rvalid && (bmem_raddr == addr_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_write) begin
          state_d = WR_DATA;
        end else if (dfp_read) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rbeat_ok && (cnt_q == LAST_BEAT)) begin
          state_d = DONE;
        end
      end
      WR_DATA: begin
        if (bmem_ready && (cnt_q == LAST_BEAT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: request latch, beat counter, fill buffer.
  // The counter wraps to 0 after the last beat; the FSM leaves the burst
  // state on that same edge, so the wrapped value is never used.
  always_comb begin
    addr_d = addr_q;
    line_d = line_q;
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_write) begin
          addr_d = aligned_addr;
          line_d = dfp_wdata;
          cnt_d  = '0;
        end else if (dfp_read) begin
          addr_d = aligned_addr;
          cnt_d  = '0;
        end
      end
      RD_DATA: begin
        if (rbeat_ok) begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              buf_d[k*BEAT_W +: BEAT_W] = bmem_rdata;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_DATA: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      line_q <= '0;
      buf_q  <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      line_q <= line_d;
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    bmem_read_d  = 1'b0;
    bmem_write_d = 1'b0;
    bmem_wdata_d = '0;
    dfp_resp_d   = 1'b0;
    unique case (state_d)
      RD_REQ: begin
        bmem_read_d = 1'b1;
      end
      WR_DATA: begin
        bmem_write_d = 1'b1;
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (cnt_d == CNT_W'(k)) begin
            bmem_wdata_d = line_d[k*BEAT_W +: BEAT_W];
          end
        end
      end
      DONE: begin
        dfp_resp_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
      dfp_resp   <= 1'b0;
    end else begin
      bmem_read  <= bmem_read_d;
      bmem_write <= bmem_write_d;
      bmem_wdata <= bmem_wdata_d;
      dfp_resp   <= dfp_resp_d;
    end
  end

  assign bmem_addr = addr_q;
  assign dfp_rdata = buf_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Bench for cacheline_adapter: table-driven transactions plus hand-written
// backpressure, stray-beat and mid-burst reset sequences. A scoreboard holds
// expected write beats, read requests and fill lines, checked as the DUT
// produces them. Outputs are sampled at the falling edge.

module tb_cacheline_adapter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  always #5 clk = ~clk;

  cacheline_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] fill;       // line the memory returns (reads only)
    logic [31:0]  exp_baddr;
    logic [255:0] exp_rdata;
    int           exp_lat;    // request cycle to dfp_resp cycle
  } vec_t;

  vec_t vecs[5];

  int n_chk    = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  int t0       = 0;
  int resp_cyc = 0;
  int prev_resp;
  bit got_resp = 1'b0;

  logic [95:0]  exp_wq[$];
  logic [31:0]  exp_rq[$];
  logic [255:0] exp_lq[$];

  task automatic check(input string nm, input logic [287:0] act, input logic [287:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h required %0h", nm, cyc_n, act, req);
  endtask

  task automatic flag(input string nm);
    n_chk++;
    $display("FAIL %s @cyc %0d: event seen, none required", nm, cyc_n);
  endtask

  // Scoreboard monitor: runs once per cycle after this cycle's inputs are set.
  task automatic mon();
    if (rst) return;
    if (bmem_write && bmem_ready) begin
      if (exp_wq.size() == 0) flag("wr_unexpected");
      else check("wr_beat", 288'({bmem_addr, bmem_wdata}), 288'(exp_wq.pop_front()));
    end
    if (bmem_read && bmem_ready) begin
      if (exp_rq.size() == 0) flag("rd_unexpected");
      else check("rd_req", 288'(bmem_addr), 288'(exp_rq.pop_front()));
    end
    if (dfp_resp) begin
      got_resp = 1'b1;
      resp_cyc = cyc_n;
      if (exp_lq.size() == 0) flag("resp_unexpected");
      else check("fill_line", 288'(dfp_rdata), 288'(exp_lq.pop_front()));
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
    end
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] ra, input logic [63:0] rd);
    @(negedge clk);
    cyc_n++;
    bmem_ready  = rdy;
    bmem_rvalid = rv;
    bmem_raddr  = ra;
    bmem_rdata  = rd;
    mon();
  endtask

  task automatic idle(input logic rdy);
    cyc(rdy, 1'b0, 32'h0, 64'h0);
  endtask

  // Present a request in the current cycle and load the scoreboard.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wdata, input logic [31:0] baddr,
                       input logic [255:0] exp_line);
    dfp_read  = rd;
    dfp_write = wr;
    dfp_addr  = addr;
    dfp_wdata = wdata;
    if (wr) begin
      for (int k = 0; k < 4; k++) exp_wq.push_back({baddr, wdata[k*64 +: 64]});
    end else if (rd) begin
      exp_rq.push_back(baddr);
    end
    exp_lq.push_back(exp_line);
    got_resp = 1'b0;
    t0 = cyc_n;
  endtask

  task automatic run_vec(input vec_t v);
    idle(1'b1);
    issue(v.rd, v.wr, v.addr, v.wdata, v.exp_baddr, v.exp_rdata);
    for (int c = 1; c <= 20 && !got_resp; c++) begin
      if (v.rd && !v.wr && c >= 2 && c <= 5) cyc(1'b1, 1'b1, v.exp_baddr, v.fill[(c-2)*64 +: 64]);
      else idle(1'b1);
    end
    if (!got_resp) flag("resp_timeout");
    else check("resp_latency", 288'(resp_cyc - t0), 288'(v.exp_lat));
  endtask

  logic [255:0] line_f, line_a, line_b, line_c, line_d, line_g, line_h, line_j;

  initial begin
    line_f = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_a = {64'hA3A3_0000_0000_00A3, 64'hA2A2_0000_0000_00A2,
              64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0};
    line_b = {64'hB3B3_B3B3_0000_0003, 64'hB2B2_B2B2_0000_0002,
              64'hB1B1_B1B1_0000_0001, 64'hB0B0_B0B0_0000_0000};
    line_c = {64'hC0DE_0003_DEAD_BEEF, 64'hC0DE_0002_CAFE_F00D,
              64'hC0DE_0001_0123_4567, 64'hC0DE_0000_89AB_CDEF};
    line_d = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
              64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    line_g = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
              64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
    line_h = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
              64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    line_j = {64'h2000_0000_0000_0033, 64'h2000_0000_0000_0022,
              64'h2000_0000_0000_0011, 64'h2000_0000_0000_0000};

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, '0,     line_f, 32'h0000_1220, line_f, 6};
    vecs[1] = '{1'b0, 1'b1, 32'h8000_00FC, line_a, '0,     32'h8000_00E0, line_f, 5};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, line_b, line_d, 32'h0000_0040, line_f, 5};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, '0,     line_c, 32'hFFFF_FFE0, line_c, 6};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_001F, line_d, '0,     32'h0000_0000, line_c, 5};

    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset state.
    idle(1'b0);
    idle(1'b0);
    check("reset_outputs", 288'({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}), 288'(0));
    check("reset_rdata", 288'(dfp_rdata), 288'(0));
    rst = 1'b0;
    idle(1'b1);

    // Table: back-to-back transactions, including read/write conflict.
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      if (i > 0) check("resp_gap", 288'(resp_cyc - prev_resp), 288'(vecs[i].exp_lat + 1));
      prev_resp = resp_cyc;
    end

    // Fill with beats arriving at cycles 4..7.
    idle(1'b1);
    issue(1'b1, 1'b0, 32'h0000_1234, '0, 32'h0000_1220, line_f);
    idle(1'b1);
    check("fill_c1_req", 288'({bmem_read, bmem_addr}), 288'({1'b1, 32'h0000_1220}));
    idle(1'b1);
    check("fill_c2_noreq", 288'(bmem_read), 288'(0));
    idle(1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 32'h0000_1220, line_f[k*64 +: 64]);
    check("fill_c7_noresp", 288'(dfp_resp), 288'(0));
    idle(1'b1);
    check("fill_resp_c8", 288'(got_resp ? resp_cyc - t0 : -1), 288'(8));
    idle(1'b1);
    check("fill_resp_one_cycle", 288'(dfp_resp), 288'(0));

    // Write with ready low for 2 cycles after A1 is accepted.
    idle(1'b1);
    issue(1'b0, 1'b1, 32'h8000_00FC, line_a, 32'h8000_00E0, line_f);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("wr_hold_c3", 288'({bmem_write, bmem_wdata}), 288'({1'b1, line_a[128 +: 64]}));
    idle(1'b0);
    check("wr_hold_c4", 288'({bmem_write, bmem_wdata}), 288'({1'b1, line_a[128 +: 64]}));
    idle(1'b1);
    check("wr_hold_c5", 288'({bmem_write, bmem_wdata}), 288'({1'b1, line_a[128 +: 64]}));
    for (int c = 0; c < 6 && !got_resp; c++) idle(1'b1);
    check("wr_bp_latency", 288'(got_resp ? resp_cyc - t0 : -1), 288'(7));

    // Read with ready low for 3 cycles in RD_REQ.
    idle(1'b1);
    issue(1'b1, 1'b0, 32'h0000_3010, '0, 32'h0000_3000, line_g);
    for (int c = 1; c <= 3; c++) begin
      idle(1'b0);
      check("rd_req_held", 288'({bmem_read, bmem_addr}), 288'({1'b1, 32'h0000_3000}));
    end
    idle(1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 32'h0000_3000, line_g[k*64 +: 64]);
    for (int c = 0; c < 6 && !got_resp; c++) idle(1'b1);
    check("rd_bp_latency", 288'(got_resp ? resp_cyc - t0 : -1), 288'(9));

    // Stray beats: in IDLE, then one with a foreign address mid-fill.
    cyc(1'b1, 1'b1, 32'h0000_1220, 64'hBAD0_BAD0_BAD0_BAD0);
    cyc(1'b1, 1'b1, 32'h0000_1220, 64'hBAD1_BAD1_BAD1_BAD1);
    issue(1'b1, 1'b0, 32'h0000_1220, '0, 32'h0000_1220, line_c);
    idle(1'b1);
    cyc(1'b1, 1'b1, 32'h0000_1220, line_c[0 +: 64]);
    cyc(1'b1, 1'b1, 32'h0000_1240, 64'hBAD2_BAD2_BAD2_BAD2);
    for (int k = 1; k < 4; k++) cyc(1'b1, 1'b1, 32'h0000_1220, line_c[k*64 +: 64]);
    for (int c = 0; c < 6 && !got_resp; c++) idle(1'b1);
    check("stray_latency", 288'(got_resp ? resp_cyc - t0 : -1), 288'(7));

    // Reset after two beats of a fill.
    idle(1'b1);
    issue(1'b1, 1'b0, 32'h0000_1220, '0, 32'h0000_1220, line_h);
    idle(1'b1);
    cyc(1'b1, 1'b1, 32'h0000_1220, line_h[0 +: 64]);
    cyc(1'b1, 1'b1, 32'h0000_1220, line_h[64 +: 64]);
    idle(1'b1);
    #2;
    rst = 1'b1;
    dfp_read = 1'b0;
    #1;
    check("midrst_outputs", 288'({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}), 288'(0));
    check("midrst_rdata", 288'(dfp_rdata), 288'(0));
    exp_lq.delete();
    cyc(1'b1, 1'b1, 32'h0000_1220, line_h[128 +: 64]);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 32'h0000_1220, line_h[192 +: 64]);
    got_resp = 1'b0;
    for (int c = 0; c < 8; c++) idle(1'b1);
    check("midrst_no_resp", 288'(got_resp), 288'(0));
    run_vec('{1'b1, 1'b0, 32'h0000_2000, '0, line_j, 32'h0000_2000, line_j, 6});

    // Everything expected was produced.
    idle(1'b1);
    check("wq_drained", 288'(exp_wq.size()), 288'(0));
    check("rq_drained", 288'(exp_rq.size()), 288'(0));
    check("lq_drained", 288'(exp_lq.size()), 288'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges the cache's 256-bit line-granular downward port to the 64-bit burst memory. It turns one line read or line writeback into a four-beat burst, then returns a single-cycle `dfp_resp` to the cache. It sits directly below the cache's `dfp_*` port and directly above the burst memory model and controller.

## Interface
Parameters:
- `LINE_W`, 256: cache line width in bits.
- `BEAT_W`, 64: memory beat width. `BEATS = LINE_W/BEAT_W` = 4, which must be a power of two.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is asynchronous and active-high.
- `dfp_addr` in 32: byte address from the cache; bits [4:0] are ignored.
- `dfp_read` in 1: line fill request, held by the cache until `dfp_resp`.
- `dfp_write` in 1: line writeback request, held by the cache until `dfp_resp`.
- `dfp_wdata` in LINE_W: line to write back.
- `dfp_rdata` out LINE_W: assembled fill line.
- `dfp_resp` out 1: one-cycle completion pulse.
- `bmem_addr` out 32: line-aligned burst address.
- `bmem_read` out 1: read burst request.
- `bmem_write` out 1: write beat valid.
- `bmem_wdata` out BEAT_W: write beat.
- `bmem_ready` in 1: memory accepts the request or beat this cycle.
- `bmem_raddr` in 32: address tag of the returning read beat.
- `bmem_rdata` in BEAT_W: read beat data.
- `bmem_rvalid` in 1: read beat valid.

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, DONE.
- **IDLE**
  - If `dfp_write` is high: latch `{dfp_addr[31:5],5'b0}` and `dfp_wdata`, clear the beat counter, go to WR_DATA.
  - Else if `dfp_read` is high: latch the aligned address, clear the counter, go to RD_REQ.
  - If both are high, the write wins.
  - Inputs are sampled only in IDLE; changes mid-transaction are ignored.
- **RD_REQ**
  - `bmem_read`=1 and `bmem_addr`=latched address.
  - When `bmem_ready`=1, the request is accepted and the next state is RD_DATA.
  - Otherwise hold, with the address stable.
- **RD_DATA**
  - A beat is accepted when `bmem_rvalid`=1 and `bmem_raddr` equals the latched address.
  - Beat k writes buffer bits [64k+:64]; the counter then increments.
  - Beats with a mismatched address are dropped.
  - After beat 3 is accepted, go to DONE.
- **WR_DATA**
  - `bmem_write`=1, `bmem_addr`=latched address, `bmem_wdata`=latched line [64k+:64].
  - The counter advances only when `bmem_ready`=1.
  - After beat 3 is accepted, go to DONE.
  - While `bmem_ready` is low the beat is held; it is never duplicated or skipped.
- **DONE**
  - `dfp_resp`=1 for exactly one cycle, then IDLE.
  - `dfp_rdata` comes from the fill buffer register. It changes only when RD_DATA accepts a beat and is otherwise held, including across writebacks.
- **Beat counter**
  - Width log2(BEATS) = 2 bits.
  - Wraps to 0 after beat 3; the FSM exit in the same cycle makes the wrap harmless.
- `bmem_rvalid` outside RD_DATA is ignored.
- **Reset**
  - Asynchronous, taking effect at any point, including mid-burst.
  - All outputs go to 0 immediately: `dfp_resp`, `dfp_rdata`, `bmem_read`, `bmem_write`, `bmem_addr`, `bmem_wdata`.
  - The FSM returns to IDLE; the latched address, buffers and counter are cleared.
  - Beats still in flight after reset are ignored (IDLE).

## Timing
- `bmem_read`/`bmem_write` and `bmem_addr`/`bmem_wdata` are functions of state and registers only, with no combinational path from `dfp_*`.
- **Read**
  - Request is seen in IDLE at cycle 0.
  - `bmem_read` is high from cycle 1 until accepted.
  - `dfp_resp` is high in the cycle after the fourth accepted beat.
- **Write**
  - Request at cycle 0.
  - With `bmem_ready` constantly high, beats go out in cycles 1–4 and `dfp_resp` is high in cycle 5.
  - Each low-`bmem_ready` cycle adds one cycle.
- **Back-to-back**
  - A new request held in the cycle after DONE starts in that cycle (IDLE).
  - Minimum gap between two `dfp_resp` pulses is 6 cycles for write→write.
- `dfp_rdata` is valid in the `dfp_resp` cycle and stable until the next fill beat.

## Test plan
- **Fill.** `dfp_addr`=0x0000_1234, `dfp_read`=1, `bmem_ready`=1. Memory returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… (`raddr` 0x0000_1220) at cycles 4–7. Required:
  - `bmem_addr`=0x0000_1220 and `bmem_read` high in cycle 1 only.
  - `dfp_resp` in cycle 8 only.
  - `dfp_rdata`={0x4444…,0x3333…,0x2222…,0x1111…}.
- **Writeback.** `dfp_addr`=0x8000_00FC, `dfp_write`=1, `dfp_wdata` words A0..A3 (A0 in the LSBs). Required:
  - `bmem_write` high in cycles 1–4 with `bmem_wdata` A0,A1,A2,A3 and `bmem_addr`=0x8000_00E0.
  - `dfp_resp` in cycle 5.
  - `dfp_rdata` unchanged from the prior fill.
- **Backpressure.**
  - `bmem_ready`=0 for 3 cycles in RD_REQ: `bmem_read`/`bmem_addr` held, read completes normally.
  - Write with `bmem_ready`=0 for 2 cycles after A1 is accepted: A2 is held for 3 cycles, each word is accepted exactly once, and `dfp_resp` is delayed 2 cycles.
- **Stray beats.**
  - `bmem_rvalid` in IDLE: ignored.
  - Beat with `bmem_raddr`=0x0000_1240 during a 0x0000_1220 fill: ignored; the fill completes only after four matching beats, with `dfp_rdata` uncontaminated.
- **Reset mid-read.** `rst` pulsed after 2 beats are accepted:
  - All outputs go to 0 in the same cycle.
  - The remaining 2 beats are ignored and no `dfp_resp` is produced.
  - A subsequent fill of 0x0000_2000 returns the correct line.
- **Conflict.** `dfp_read`=`dfp_write`=1 in IDLE: a write burst is performed and `bmem_read` is never asserted.
